game_flow_ctrl: RTL and testbench

//  Parametrised game-flow sequencer: runs N levels, tracks lives, score and pause.

---
 rtl/game_flow_ctrl.sv | 116 +++++++++++
 tb/tb_game_flow_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: multi-level game sequencer tracking level, lives, score and pause.
module game_flow_ctrl #(
  parameter int NUM_LEVELS  = 4,
  parameter int LEVEL_W     = 3,
  parameter int SCORE_W     = 8,
  parameter int LIVES       = 3,
  parameter int INIT_CYCLES = 16,
  parameter int KILL_PTS    = 1,
  parameter int LEVEL_BONUS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               win,
  input  logic               tank_destroyed,
  input  logic               kill,
  output logic [LEVEL_W-1:0] level,
  output logic               level_init,
  output logic               playing,
  output logic               paused,
  output logic               success,
  output logic               failed,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives
);
  localparam int CW = $clog2(INIT_CYCLES + 1);
  localparam logic [31:0] SMAX = 32'((2 ** SCORE_W) - 1);
  typedef enum logic [6:0] {
    S_START   = 7'b0000001,
    S_INIT    = 7'b0000010,
    S_PLAY    = 7'b0000100,
    S_PAUSE   = 7'b0001000,
    S_DIED    = 7'b0010000,
    S_SUCCESS = 7'b0100000,
    S_FAILED  = 7'b1000000
  } state_t;
  state_t state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0] lives_q, lives_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] sum;
  logic [SCORE_W-1:0] score_sat;
  always_comb begin
    sum = 32'(score_q) + (kill ? 32'(KILL_PTS) : 32'd0)
        + ((win && !tank_destroyed) ? 32'(LEVEL_BONUS) : 32'd0);
    score_sat = (sum > SMAX) ? SCORE_W'(SMAX) : SCORE_W'(sum);
    state_d = state_q;
    level_d = level_q;
    score_d = score_q;
    lives_d = lives_q;
    cnt_d = cnt_q;
    unique case (state_q)
      S_START: if (start) begin
        state_d = S_INIT;
        level_d = LEVEL_W'(1);
        score_d = '0;
        lives_d = 3'(LIVES);
        cnt_d = '0;
      end
      S_INIT: begin
        state_d = (cnt_q == CW'(INIT_CYCLES - 1)) ? S_PLAY : S_INIT;
        cnt_d = cnt_q + CW'(1);
      end
      S_PLAY: begin
        score_d = score_sat;
        cnt_d = '0;
        if (tank_destroyed) begin
          lives_d = lives_q - 3'd1;
          state_d = (lives_q == 3'd1) ? S_FAILED : S_DIED;
        end else if (win) begin
          state_d = (level_q == LEVEL_W'(NUM_LEVELS)) ? S_SUCCESS : S_INIT;
          level_d = (level_q == LEVEL_W'(NUM_LEVELS)) ? level_q : level_q + LEVEL_W'(1);
        end else if (pause) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: state_d = start ? S_START : (pause ? S_PLAY : S_PAUSE);
      S_DIED: begin
        state_d = S_INIT;
        cnt_d = '0;
      end
      default: state_d = start ? S_START : state_q;
    endcase
    // every route back to START clears the game so the display shows a fresh screen
    if (state_d == S_START && state_q != S_START) begin
      level_d = '0;
      score_d = '0;
      lives_d = 3'(LIVES);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_START;
      level_q <= '0;
      score_q <= '0;
      lives_q <= 3'(LIVES);
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      score_q <= score_d;
      lives_q <= lives_d;
      cnt_q <= cnt_d;
    end
  end
  assign level = level_q;
  assign score = score_q;
  assign lives = lives_q;
  assign level_init = state_q == S_INIT;
  assign playing = state_q == S_PLAY;
  assign paused = state_q == S_PAUSE;
  assign success = state_q == S_SUCCESS;
  assign failed = state_q == S_FAILED;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed plus random checks of game_flow_ctrl against a behavioural game model.
module tb_game_flow_ctrl;
  localparam int ST_START = 0, ST_INIT = 1, ST_PLAY = 2, ST_PAUSE = 3, ST_DIED = 4, ST_SUCC = 5, ST_FAIL = 6;
  typedef struct {
    int st;
    int level;
    int score;
    int lives;
    int init_left;
  } mdl_t;
  logic clk = 0, rst = 0, start = 0, pause = 0, win = 0, tank_destroyed = 0, kill = 0;
  logic [2:0] level, level2, lives, lives2;
  logic level_init, playing, paused, success, failed;
  logic level_init2, playing2, paused2, success2, failed2;
  logic [7:0] score;
  logic [3:0] score2;
  int errors = 0, checks = 0;
  mdl_t m1, m2;
  game_flow_ctrl dut (.clk(clk), .rst(rst), .start(start), .pause(pause), .win(win),
    .tank_destroyed(tank_destroyed), .kill(kill), .level(level), .level_init(level_init),
    .playing(playing), .paused(paused), .success(success), .failed(failed),
    .score(score), .lives(lives));
  game_flow_ctrl #(.SCORE_W(4)) dut2 (.clk(clk), .rst(rst), .start(start), .pause(pause), .win(win),
    .tank_destroyed(tank_destroyed), .kill(kill), .level(level2), .level_init(level_init2),
    .playing(playing2), .paused(paused2), .success(success2), .failed(failed2),
    .score(score2), .lives(lives2));
  always #5 clk = ~clk;
  function automatic mdl_t fresh();
    mdl_t m;
    m.st = ST_START; m.level = 0; m.score = 0; m.lives = 3; m.init_left = 0;
    return m;
  endfunction
  // one game tick: what a player would see happen after this cycle's inputs
  function automatic mdl_t step(mdl_t m, bit s, bit p, bit w, bit t, bit k, int smax);
    mdl_t n = m;
    int pts;
    case (m.st)
      ST_START: if (s) begin n = fresh(); n.st = ST_INIT; n.level = 1; n.init_left = 16; end
      ST_INIT: begin n.init_left = m.init_left - 1; if (n.init_left == 0) n.st = ST_PLAY; end
      ST_PLAY: begin
        pts = k ? 1 : 0;
        if (t) begin
          n.lives = m.lives - 1;
          n.st = (n.lives == 0) ? ST_FAIL : ST_DIED;
        end else if (w) begin
          pts += 10;
          if (m.level == 4) n.st = ST_SUCC;
          else begin n.level = m.level + 1; n.st = ST_INIT; n.init_left = 16; end
        end else if (p) n.st = ST_PAUSE;
        n.score = (m.score + pts > smax) ? smax : m.score + pts;
      end
      ST_PAUSE: if (s) n = fresh(); else if (p) n.st = ST_PLAY;
      ST_DIED: begin n.st = ST_INIT; n.init_left = 16; end
      default: if (s) n = fresh();
    endcase
    return n;
  endfunction
  function automatic logic [18:0] pack(mdl_t m);
    return {3'(m.level), m.st == ST_INIT, m.st == ST_PLAY, m.st == ST_PAUSE,
            m.st == ST_SUCC, m.st == ST_FAIL, 8'(m.score), 3'(m.lives)};
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin m1 = fresh(); m2 = fresh(); end
    else begin
      m1 = step(m1, start, pause, win, tank_destroyed, kill, 255);
      m2 = step(m2, start, pause, win, tank_destroyed, kill, 15);
    end
  end
  always @(negedge clk) begin
    logic [18:0] a1, a2;
    a1 = {level, level_init, playing, paused, success, failed, score, lives};
    a2 = {level2, level_init2, playing2, paused2, success2, failed2, 4'd0, score2, lives2};
    checks += 2;
    if (a1 !== pack(m1)) begin errors++; $display("FAIL outputs8 t=%0t act=%h exp=%h", $time, a1, pack(m1)); end
    if (a2 !== pack(m2)) begin errors++; $display("FAIL outputs4 t=%0t act=%h exp=%h", $time, a2, pack(m2)); end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin errors++; $display("FAIL %s act=%0d exp=%0d", name, act, exp); end
  endtask
  task automatic cyc(input bit s, input bit p, input bit w, input bit t, input bit k);
    start = s; pause = p; win = w; tank_destroyed = t; kill = k;
    @(posedge clk); #1;
    start = 0; pause = 0; win = 0; tank_destroyed = 0; kill = 0;
  endtask
  task automatic wait_play();
    int n = 0;
    while (!playing && n < 64) begin cyc(0, 0, 0, 0, 0); n++; end
    chk("wait_play", int'(playing), 1);
  endtask
  initial begin
    int n;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_level", int'(level), 0); chk("rst_lives", int'(lives), 3);
    chk("rst_score", int'(score), 0); chk("rst_init", int'(level_init), 0);
    cyc(1, 0, 0, 0, 0);
    n = 0;
    while (level_init && n < 40) begin n++; cyc(0, 0, 0, 0, 0); end
    chk("init_len", n, 16); chk("init_level", int'(level), 1); chk("init_play", int'(playing), 1);
    for (int i = 0; i < 4; i++) begin wait_play(); cyc(0, 0, 1, 0, 0); end
    chk("all_success", int'(success), 1); chk("all_level", int'(level), 4); chk("all_score", int'(score), 40);
    cyc(1, 0, 0, 0, 0);
    chk("restart_level", int'(level), 0); chk("restart_score", int'(score), 0);
    cyc(1, 0, 0, 0, 0); wait_play();
    repeat (3) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    chk("kw_score", int'(score), 13); chk("kw_level", int'(level), 2); chk("kw_init", int'(level_init), 1);
    for (int i = 0; i < 3; i++) begin wait_play(); cyc(0, 0, 0, 1, 0); chk("hit_lives", int'(lives), 2 - i); end
    chk("hit_failed", int'(failed), 1);
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); wait_play();
    cyc(0, 0, 1, 1, 0);
    chk("wt_lives", int'(lives), 2); chk("wt_level", int'(level), 1); chk("wt_score", int'(score), 0);
    wait_play();
    cyc(0, 1, 0, 0, 0); chk("pause_on", int'(paused), 1);
    cyc(0, 0, 0, 0, 1); chk("pause_kill", int'(score), 0);
    cyc(0, 1, 0, 0, 0); chk("pause_off", int'(playing), 1);
    cyc(0, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
    chk("abort_level", int'(level), 0); chk("abort_paused", int'(paused), 0);
    cyc(1, 0, 0, 0, 0); repeat (5) cyc(0, 0, 0, 0, 0);
    #2 rst = 1;
    #1 chk("arst_level", int'(level), 0); chk("arst_init", int'(level_init), 0);
    @(posedge clk); #1 rst = 0;
    cyc(1, 0, 0, 0, 0); wait_play();
    repeat (20) cyc(0, 0, 0, 0, 1);
    chk("kills_score8", int'(score), 20); chk("kills_score4", int'(score2), 15);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 1; @(posedge clk); #1 rst = 0;
      end else
        cyc($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
